// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// Result is {remainder, quotient}; the writeback path splits it into HI/LO.
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BYZERO = 2'b01;
  localparam logic [1:0] ON     = 2'b10;
  localparam logic [1:0] END    = 2'b11;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] divisor;
  logic              dividend_neg;
  logic              divisor_neg;
  logic              is_signed;

  logic [DATA_W-1:0] abs_dividend;
  logic [DATA_W-1:0] abs_divisor;
  logic [DATA_W:0]   partial;
  logic [DATA_W+1:0] diff;
  logic              trial_ok;
  logic              quo_negate;
  logic              rem_negate;
  logic [DATA_W-1:0] quo_fixed;
  logic [DATA_W-1:0] rem_fixed;

  // Magnitudes only; the sign is reapplied once the unsigned division is done.
  assign abs_dividend = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign abs_divisor  = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

  // The shifted partial remainder can need one bit more than DATA_W, and the
  // subtraction one more again so that its sign bit is unambiguous.
  assign partial  = {rem, quo[DATA_W-1]};
  assign diff     = {1'b0, partial} - {2'b00, divisor};
  assign trial_ok = ~diff[DATA_W+1];

  assign quo_negate = is_signed && (dividend_neg ^ divisor_neg);
  assign rem_negate = is_signed && dividend_neg;
  assign quo_fixed  = quo_negate ? -quo : quo;
  assign rem_fixed  = rem_negate ? -rem : rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      rem          <= '0;
      quo          <= '0;
      divisor      <= '0;
      dividend_neg <= 1'b0;
      divisor_neg  <= 1'b0;
      is_signed    <= 1'b0;
      result_o     <= '0;
      ready_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (start_i && !annul_i) begin
            if (opdata2_i == '0) begin
              state <= BYZERO;
            end else begin
              state        <= ON;
              quo          <= abs_dividend;
              rem          <= '0;
              divisor      <= abs_divisor;
              dividend_neg <= opdata1_i[DATA_W-1];
              divisor_neg  <= opdata2_i[DATA_W-1];
              is_signed    <= signed_div_i;
              cnt          <= '0;
            end
          end
        end

        // Divide-by-zero is defined to produce an all-zero result.
        BYZERO: begin
          if (annul_i) begin
            state <= IDLE;
          end else begin
            state     <= END;
            rem       <= '0;
            quo       <= '0;
            is_signed <= 1'b0;
          end
        end

        // The dividend is shifted out of quo while quotient bits shift in.
        ON: begin
          if (annul_i) begin
            state <= IDLE;
          end else begin
            rem <= trial_ok ? diff[DATA_W-1:0] : partial[DATA_W-1:0];
            quo <= {quo[DATA_W-2:0], trial_ok};
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(DATA_W - 1)) begin
              state <= END;
            end
          end
        end

        END: begin
          if (start_i) begin
            ready_o  <= 1'b1;
            result_o <= {rem_fixed, quo_fixed};
          end else begin
            state    <= IDLE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider serving DIV/DIVU in the EX stage.
- Produces a 64-bit {remainder, quotient} result that the writeback path splits into the HI/LO register.
  - remainder goes to HI; quotient goes to LO.
- EX stalls the pipeline while the divider is busy.
- Annul lets exception/flush logic abort an in-flight divide.

Parameters:
- DATA_W, 32, operand width in bits; result width is 2*DATA_W.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- signed_div_i  input  1  1 = DIV (two's complement), 0 = DIVU
- opdata1_i  input  DATA_W  dividend
- opdata2_i  input  DATA_W  divisor
- start_i  input  1  request; held high by EX until ready_o seen
- annul_i  input  1  abort current operation
- result_o  output  2*DATA_W  {remainder, quotient}
- ready_o  output  1  result valid

Behaviour:
- Reset (rst=1 at edge): state=IDLE, result_o=0, ready_o=0, cnt=0, internal regs=0. Reset overrides all other inputs in every state, including mid-operation.
- States: IDLE, BYZERO, ON, END; two-bit encoding.
- IDLE:
  - start_i=1, annul_i=0, opdata2_i==0 -> BYZERO.
  - start_i=1, annul_i=0, opdata2_i!=0 -> ON. On this edge:
    - latch the absolute values of both operands (signed_div_i=1 and MSB set -> two's-complement negate);
    - latch the operand signs and signed_div_i;
    - cnt=0.
  - Otherwise stay in IDLE. ready_o=0, result_o=0.
- BYZERO: next edge -> END with result 0. Divide-by-zero result is decided as quotient=0, remainder=0.
- ON: one restoring step per cycle.
  - Shift {rem, quo} left by 1 and compute trial = rem - divisor (DATA_W+1 bits).
  - trial non-negative -> rem=trial, quotient bit=1; else quotient bit=0.
  - cnt increments per step. After the 32nd step (cnt==DATA_W) the next edge -> END with the sign fix applied:
    - signed and operand signs differ -> quotient negated;
    - signed and dividend negative -> remainder negated.
  - annul_i=1 at any ON edge -> IDLE, ready_o stays 0, partial result discarded.
- BYZERO honours annul_i the same way as ON.
- END:
  - ready_o=1 and result_o holds the final value, held for as long as start_i=1.
  - start_i=0 at edge -> IDLE, ready_o=0, result_o=0.
  - annul_i is ignored in END.
- Latency, with start sampled at edge E0:
  - nonzero divisor: ready_o rises after edge E33 (E0 load, E1..E32 iterate, E33 finalize);
  - zero divisor: ready_o rises after edge E2.
- Width rules:
  - Unsigned: plain DATA_W-bit arithmetic.
  - Signed: magnitudes in DATA_W bits. Signed -2^31 / -1 gives quotient 0x80000000, remainder 0 (wraps, no trap).
- Operand changes on opdata1_i/opdata2_i after the IDLE->ON edge have no effect.
- Back-to-back: a new start is accepted only from IDLE, i.e. start_i must drop for at least one edge between operations.

Test Plan:
- Unsigned 100/7 (signed_div_i=0) -> ready_o after 33 edges, result_o = {32'd2, 32'd14}; start_i dropped -> ready_o=0, result_o=0 next cycle.
- Signed -7/2 (0xFFFFFFF9 / 0x2) -> result_o = {0xFFFFFFFF, 0xFFFFFFFD}. Signed 7/-2 -> {0x00000001, 0xFFFFFFFD}.
- Divide by zero, 0x1234/0 -> ready_o after 2 edges, result_o=0. Also check 0xFFFFFFFF/0xFFFFFFFF unsigned -> {0, 1}.
- Signed 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}. The same operands unsigned -> {0x80000000, 0x00000000}.
- annul_i pulsed at the 10th ON cycle -> ready_o never asserts, state IDLE. A new start with 50/5 then yields {0, 10} after 33 edges.
- rst asserted at the 20th ON cycle -> next cycle ready_o=0, result_o=0, IDLE. Holding start_i high through start/END keeps result_o stable for 5+ cycles.
